stream_demux_1_to_4: RTL

Registered 1-to-4 stream demultiplexer: the distribution-side counterpart of the 4-to-1 selector. One valid/ready input channel carries a data word plus a 2-bit destination select. The block steers each accepted word into one of four output channels, each with its own single-entry holding register and a saturating delivered-beat counter. It sits between a single producer and four independent consumers, and back-pressures the producer per destination.

---
 rtl/stream_demux_pkg.sv | 13 +
 rtl/stream_demux_if.sv | 34 +++
 rtl/demux_slot.sv | 65 ++++++
 rtl/stream_demux_1_to_4.sv | 59 +++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
//   NUM_OUT     : number of output channels
//   SEL_W       : width of the destination select
//   DEF_WIDTH   : default data word width
//   DEF_CNT_W   : default width of each delivered-beat counter
package stream_demux_pkg;

  localparam int unsigned NUM_OUT   = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/stream_demux_if.sv
// Bundle of the demux handshake and data signals.
//   in_valid/in_ready/in_data/in_sel : producer channel with destination select
//   out_valid/out_ready/out_data     : four consumer channels, slice k = channel k
//   beat_cnt                         : per-output delivered-beat counters, slice k
//   clr_cnt                          : synchronous clear of all counters
// Modport master = producer/consumer side, slave = the demux.
interface stream_demux_if
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic [SEL_W-1:0]           in_sel;
  logic [NUM_OUT-1:0]         out_valid;
  logic [NUM_OUT-1:0]         out_ready;
  logic [NUM_OUT*WIDTH-1:0]   out_data;
  logic [NUM_OUT*CNT_W-1:0]   beat_cnt;
  logic                       clr_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready, clr_cnt,
    input  in_ready, out_valid, out_data, beat_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready, clr_cnt,
    output in_ready, out_valid, out_data, beat_cnt
  );

endinterface

// File: rtl/demux_slot.sv
// One output channel of the demux: single-entry holding register plus a
// saturating delivered-beat counter.
//   clk, rst : clock, synchronous active-high reset
//   load_i   : write data_i into the slot this cycle (caller guarantees room)
//   data_i   : word to store
//   ready_i  : consumer takes the held word
//   clr_i    : zero the counter (wins over a same-cycle increment)
//   valid_o  : slot holds a word
//   data_o   : held word, kept after a drain
//   cnt_o    : number of drains, saturating
module demux_slot #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  input  logic             clr_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain;

  always_comb begin
    drain  = full_q && ready_i;
    full_d = full_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (drain) full_d = 1'b0;
    // A load in the same cycle as a drain keeps the slot full with the new word.
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
    if (clr_i) begin
      cnt_d = '0;
    end else if (drain && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/stream_demux_1_to_4.sv
// Registered 1-to-4 stream demultiplexer. Each accepted input word is steered
// by in_sel into one of four single-entry output slots; the producer is
// back-pressured only by the slot it currently addresses.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of stream_demux_if (input channel, four output
//              channels, per-output beat counters, counter clear)
module stream_demux_1_to_4
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  stream_demux_if.slave  bus
);

  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] load_en;
  logic               in_ready;
  logic [WIDTH-1:0]   slot_data [NUM_OUT];
  logic [CNT_W-1:0]   slot_cnt  [NUM_OUT];

  // Ready depends only on the addressed slot, never on in_valid.
  always_comb begin
    in_ready = !rst && (!full[bus.in_sel] || bus.out_ready[bus.in_sel]);
    load_en  = '0;
    load_en[bus.in_sel] = bus.in_valid && in_ready;
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_en[k]),
      .data_i  (bus.in_data),
      .ready_i (bus.out_ready[k]),
      .clr_i   (bus.clr_cnt),
      .valid_o (full[k]),
      .data_o  (slot_data[k]),
      .cnt_o   (slot_cnt[k])
    );
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = full;
    bus.out_data  = '0;
    bus.beat_cnt  = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      bus.out_data[k*WIDTH +: WIDTH] = slot_data[k];
      bus.beat_cnt[k*CNT_W +: CNT_W] = slot_cnt[k];
    end
  end

endmodule
